// File: rtl/uart_pkg.sv
// Shared UART definitions for the byte transmitter and receiver.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      UART_IDLE   = 3'd0,
      UART_START  = 3'd1,
      UART_DATA   = 3'd2,
      UART_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , UART_PARITY = 3'd4
`endif
   } uart_state_e;

   // Width of a counter that must hold 0..oversample-1.
   function automatic int uart_tick_cnt_w(input int oversample);
      return (oversample < 2) ? 1 : $clog2(oversample);
   endfunction

endpackage

// File: rtl/uart_transmitter_byte_if.sv
// Host-side byte handshake into the UART transmitter.
interface uart_transmitter_byte_if;
   import uart_pkg::*;

   // A byte moves on every clk edge where data_valid and ready are both high;
   // data must be stable in that cycle and is ignored at all other times.
   logic [UART_DATA_BITS-1:0] data;
   logic                      data_valid;
   logic                      ready;

   modport master (output data, output data_valid, input ready);
   modport slave  (input data, input data_valid, output ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Counts baud_tick strobes and flags the clk where a bit period ends.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic baud_tick,
   input  logic clr,
   output logic bit_end
);

   localparam int W = uart_tick_cnt_w(OVERSAMPLE);
   localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // A clear wins over a coincident tick, so that tick is simply dropped.
   assign bit_end = baud_tick && !clr && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (baud_tick) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter_byte.sv
// UART byte transmitter: start, 8 data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_transmitter_byte
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    baud_tick,
   uart_transmitter_byte_if.slave  host,
   output logic                    tx,
   output logic                    tx_done,
   output uart_state_e             state_dbg
);

   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   uart_state_e               state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic                      tx_q, tx_d;
   logic                      ready_q, ready_d;
   logic                      tx_done_q, tx_done_d;
   logic                      accept;
   logic                      bit_end;
`ifdef UART_TX_PARITY_EN
   logic                      parity_q, parity_d;
`endif

   assign accept = (state_q == UART_IDLE) && host.data_valid;

   uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
      .clk       (clk),
      .rst       (rst),
      .baud_tick (baud_tick),
      .clr       (accept),
      .bit_end   (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         UART_IDLE: begin
            if (accept) begin
               state_d   = UART_START;
               shift_d   = host.data;
               bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^host.data;
`endif
            end
         end
         UART_START: begin
            if (bit_end) state_d = UART_DATA;
         end
         UART_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = UART_PARITY;
`else
                  state_d   = UART_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         UART_PARITY: begin
            if (bit_end) state_d = UART_STOP;
         end
`endif
         UART_STOP: begin
            // bit_cnt is reused here to count stop-bit periods.
            if (bit_end) begin
               if (bit_cnt_q == STOP_LAST) begin
                  state_d   = UART_IDLE;
                  bit_cnt_d = '0;
                  tx_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = UART_IDLE;
      endcase

      // Outputs are registered from the next state so they move with it.
      case (state_d)
         UART_START:  tx_d = 1'b0;
         UART_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         UART_PARITY: tx_d = parity_d;
`endif
         default:     tx_d = UART_IDLE_LEVEL;
      endcase
      ready_d = (state_d == UART_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= UART_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= UART_IDLE_LEVEL;
         ready_q   <= 1'b1;
         tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign tx_done    = tx_done_q;
   assign host.ready = ready_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_transmitter_byte.sv
// Directed bench for uart_transmitter_byte (1 and 2 stop-bit instances).
module tb_uart_transmitter_byte;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        baud_tick = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        valid1 = 1'b0;
   logic        valid2 = 1'b0;
   int          sel = 0;
   int          tick_div = 0;
   int          checks = 0;
   int          passed = 0;

   logic        tx1, tx2, done1, done2;
   uart_state_e st1, st2;
   logic        tx_m, ready_m, done_m;

   uart_transmitter_byte_if if1 ();
   uart_transmitter_byte_if if2 ();

   assign if1.data       = data_in;
   assign if1.data_valid = valid1;
   assign if2.data       = data_in;
   assign if2.data_valid = valid2;

   uart_transmitter_byte #(.OVERSAMPLE(16), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .host(if1.slave),
      .tx(tx1), .tx_done(done1), .state_dbg(st1)
   );

   uart_transmitter_byte #(.OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .host(if2.slave),
      .tx(tx2), .tx_done(done2), .state_dbg(st2)
   );

   assign tx_m    = (sel == 1) ? tx2       : tx1;
   assign ready_m = (sel == 1) ? if2.ready : if1.ready;
   assign done_m  = (sel == 1) ? done2     : done1;

   // clock and baud tick (one tick every 10 clk)
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         tick_div  = (tick_div == 9) ? 0 : tick_div + 1;
         baud_tick = (tick_div == 0);
      end
   end

   // driver tasks
   task automatic set_valid(input logic v);
      if (sel == 1) valid2 = v;
      else          valid1 = v;
   endtask

   task automatic start_frame(input logic [7:0] b);
      @(posedge clk);
      #2;
      data_in = b;
      set_valid(1'b1);
      @(posedge clk);
      #2;
      set_valid(1'b0);
   endtask

   // Follows one frame from the cycle after accept to the tx_done cycle.
   task automatic check_frame(input logic [7:0] b, input int sb, input int inject_at,
                              output int bit1_cyc, output int stop_cyc);
      logic exp_bits [0:11];
      int   nb, k, cyc, idx, errs, f_idx;
      logic f_tx, f_rdy, f_done;
      nb = 10 + sb - 1;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
      nb = nb + 1;
      exp_bits[9] = ^b;
      for (int i = 10; i < 12; i++) exp_bits[i] = 1'b1;
`else
      for (int i = 9; i < 12; i++) exp_bits[i] = 1'b1;
`endif
      k = 0; cyc = 0; errs = 0; bit1_cyc = 0; stop_cyc = 0;
      f_idx = 0; f_tx = 1'b0; f_rdy = 1'b0; f_done = 1'b0;
      while (k < nb * 16 && cyc < 4000) begin
         @(negedge clk);
         idx = k / 16;
         if (inject_at >= 0 && cyc == inject_at) begin
            data_in = 8'hFF;
            set_valid(1'b1);
         end
         if (inject_at >= 0 && cyc == inject_at + 300) set_valid(1'b0);
         if (tx_m !== exp_bits[idx] || ready_m !== 1'b0 || done_m !== 1'b0) begin
            if (errs == 0) begin
               f_idx = idx; f_tx = tx_m; f_rdy = ready_m; f_done = done_m;
            end
            errs++;
         end
         if (idx == 1) bit1_cyc++;
         if (idx >= nb - sb) stop_cyc++;
         if (baud_tick) k++;
         cyc++;
      end
      if (inject_at >= 0) set_valid(1'b0);
      checks++;
      if (errs == 0 && k == nb * 16) passed++;
      else $display("FAIL frame_%h: %0d bad cycles, first at bit %0d got tx=%b ready=%b done=%b, want tx=%b ready=0 done=0; ticks %0d of %0d",
                    b, errs, f_idx, f_tx, f_rdy, f_done, exp_bits[f_idx], k, nb * 16);
      @(negedge clk);
      checks++;
      if (done_m === 1'b1 && ready_m === 1'b1 && tx_m === 1'b1) passed++;
      else $display("FAIL end_%h: done=%b ready=%b tx=%b, want 1 1 1", b, done_m, ready_m, tx_m);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (tx1 === 1'b1 && if1.ready === 1'b1 && done1 === 1'b0 && st1 === UART_IDLE) passed++;
      else $display("FAIL reset_dut1: tx=%b ready=%b done=%b st=%0d, want 1 1 0 0", tx1, if1.ready, done1, st1);
      checks++;
      if (tx2 === 1'b1 && if2.ready === 1'b1 && done2 === 1'b0 && st2 === UART_IDLE) passed++;
      else $display("FAIL reset_dut2: tx=%b ready=%b done=%b st=%0d, want 1 1 0 0", tx2, if2.ready, done2, st2);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (tx1 === 1'b1 && if1.ready === 1'b1 && done1 === 1'b0) passed++;
      else $display("FAIL idle_after_reset: tx=%b ready=%b done=%b, want 1 1 0", tx1, if1.ready, done1);
   endtask

   task automatic test_single_byte();
      int b1, sc;
      sel = 0;
      start_frame(8'h35);
      check_frame(8'h35, 1, -1, b1, sc);
      checks++;
      if (b1 == 160) passed++;
      else $display("FAIL bit_width: got %0d clk, want 160", b1);
      @(negedge clk);
      checks++;
      if (done1 === 1'b0 && if1.ready === 1'b1 && tx1 === 1'b1) passed++;
      else $display("FAIL done_pulse_width: done=%b ready=%b tx=%b, want 0 1 1", done1, if1.ready, tx1);
   endtask

   task automatic test_accept_mid_frame();
      int b1, sc;
      sel = 0;
      start_frame(8'h3C);
      check_frame(8'h3C, 1, 400, b1, sc);
      repeat (3) @(negedge clk);
      checks++;
      if (tx1 === 1'b1 && if1.ready === 1'b1 && st1 === UART_IDLE) passed++;
      else $display("FAIL no_late_accept: tx=%b ready=%b st=%0d, want 1 1 0", tx1, if1.ready, st1);
   endtask

   task automatic test_back_to_back();
      int b1, sc;
      sel = 0;
      @(posedge clk);
      #2;
      data_in = 8'hA5;
      valid1  = 1'b1;
      @(posedge clk);
      #2;
      data_in = 8'h00;
      check_frame(8'hA5, 1, -1, b1, sc);
      @(posedge clk);
      #2;
      valid1 = 1'b0;
      check_frame(8'h00, 1, -1, b1, sc);
   endtask

   task automatic test_reset_mid_frame();
      int  k, cyc, bad, b1, sc;
      sel = 0;
      start_frame(8'hC3);
      k = 0; cyc = 0;
      while (k < 4 * 16 + 5 && cyc < 2000) begin
         @(negedge clk);
         if (baud_tick) k++;
         cyc++;
      end
      @(negedge clk);
      checks++;
      if (tx1 === 1'b0 && st1 === UART_DATA) passed++;
      else $display("FAIL in_data_bit3: tx=%b st=%0d, want 0 2", tx1, st1);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (tx1 === 1'b1 && if1.ready === 1'b1 && done1 === 1'b0 && st1 === UART_IDLE) passed++;
      else $display("FAIL async_abort: tx=%b ready=%b done=%b st=%0d, want 1 1 0 0", tx1, if1.ready, done1, st1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done1 !== 1'b0 || tx1 !== 1'b1 || if1.ready !== 1'b1) bad++;
      end
      checks++;
      if (bad == 0) passed++;
      else $display("FAIL quiet_after_abort: %0d bad cycles, want 0", bad);
      start_frame(8'h5A);
      check_frame(8'h5A, 1, -1, b1, sc);
   endtask

   task automatic test_two_stop_bits();
      logic [7:0] vec [0:2];
      int b1, sc;
      vec[0] = 8'h00; vec[1] = 8'h55; vec[2] = 8'hFF;
      sel = 1;
      for (int i = 0; i < 3; i++) begin
         start_frame(vec[i]);
         check_frame(vec[i], 2, -1, b1, sc);
         checks++;
         if (sc == 320 && b1 == 160) passed++;
         else $display("FAIL stop2_%h: stop=%0d bit1=%0d clk, want 320 160", vec[i], sc, b1);
      end
      sel = 0;
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int b1, sc;
      sel = 0;
      start_frame(8'h34);
      check_frame(8'h34, 1, -1, b1, sc);
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_accept_mid_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_two_stop_bits();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
